// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one downstream AXI read port between two upstream
//               masters. Only one burst is outstanding at a time; masters
//               compete in IDLE with round-robin tie-breaking.
// Ports       :
//    clk, sys_rst_n         - clock, synchronous active-low reset
//    m0_ar*, m1_ar*         - upstream read-address channels (inputs + arready)
//    m0_r*,  m1_r*          - upstream read-data channels (outputs + rready)
//    s_ar*                  - downstream read-address channel to memory
//    s_r*                   - downstream read-data channel from memory
//    grant                  - index of the master owning the port
//    busy                   - high whenever the FSM is not IDLE
//    protocol_err           - sticky flag: rlast disagreed with burst length
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   // master 0 read address
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [7:0]        m0_arlen,
   input  logic [2:0]        m0_arsize,
   input  logic [1:0]        m0_arburst,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   // master 0 read data
   output logic [ID_W-1:0]   m0_rid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   // master 1 read address
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [7:0]        m1_arlen,
   input  logic [2:0]        m1_arsize,
   input  logic [1:0]        m1_arburst,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   // master 1 read data
   output logic [ID_W-1:0]   m1_rid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   // downstream read address
   output logic [ID_W-1:0]   s_arid,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [7:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   output logic              s_arvalid,
   input  logic              s_arready,
   // downstream read data
   input  logic [ID_W-1:0]   s_rid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic              s_rvalid,
   output logic              s_rready,
   // status
   output logic              grant,
   output logic              busy,
   output logic              protocol_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_grant;
   logic        r_last_grant;
   logic [7:0]  r_len_q;
   logic [7:0]  r_beat_cnt;
   logic        r_protocol_err;

   logic        w_in_addr;
   logic        w_in_data;
   logic        w_g_arvalid;
   logic [7:0]  w_g_arlen;
   logic        w_g_rready;
   logic        w_m0_sel;
   logic        w_m1_sel;
   logic        w_ar_hs;
   logic        w_r_hs;
   logic        w_len_match;

   assign w_in_addr = (r_state == ST_ADDR);
   assign w_in_data = (r_state == ST_DATA);

   // Granted-master selection for the address channel. The s_ar payload
   // follows the grant at all times; only s_arvalid is qualified by state.
   assign w_g_arvalid = r_grant ? m1_arvalid : m0_arvalid;
   assign w_g_arlen   = r_grant ? m1_arlen   : m0_arlen;
   assign w_g_rready  = r_grant ? m1_rready  : m0_rready;

   assign s_arid    = r_grant ? m1_arid    : m0_arid;
   assign s_araddr  = r_grant ? m1_araddr  : m0_araddr;
   assign s_arlen   = w_g_arlen;
   assign s_arsize  = r_grant ? m1_arsize  : m0_arsize;
   assign s_arburst = r_grant ? m1_arburst : m0_arburst;
   assign s_arvalid = w_in_addr & w_g_arvalid;

   // arready depends only on state, grant and s_arready -- never on s_r*.
   assign m0_arready = w_in_addr & ~r_grant & s_arready;
   assign m1_arready = w_in_addr &  r_grant & s_arready;

   // rready depends only on state, grant and the granted master's rready --
   // never on any upstream valid.
   assign s_rready = w_in_data & w_g_rready;

   assign w_m0_sel = w_in_data & ~r_grant;
   assign w_m1_sel = w_in_data &  r_grant;

   assign m0_rvalid = w_m0_sel & s_rvalid;
   assign m0_rid    = w_m0_sel ? s_rid   : '0;
   assign m0_rdata  = w_m0_sel ? s_rdata : '0;
   assign m0_rresp  = w_m0_sel ? s_rresp : '0;
   assign m0_rlast  = w_m0_sel & s_rlast;

   assign m1_rvalid = w_m1_sel & s_rvalid;
   assign m1_rid    = w_m1_sel ? s_rid   : '0;
   assign m1_rdata  = w_m1_sel ? s_rdata : '0;
   assign m1_rresp  = w_m1_sel ? s_rresp : '0;
   assign m1_rlast  = w_m1_sel & s_rlast;

   assign w_ar_hs     = s_arvalid & s_arready;
   assign w_r_hs      = w_in_data & s_rvalid & s_rready;
   // beat_cnt counts beats already accepted, so the final beat sees
   // beat_cnt == len_q (arlen is beats-minus-one).
   assign w_len_match = (r_beat_cnt == r_len_q);

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         r_state        <= ST_IDLE;
         r_grant        <= 1'b0;
         r_last_grant   <= 1'b1;   // m0 wins the first tie
         r_len_q        <= 8'd0;
         r_beat_cnt     <= 8'd0;
         r_protocol_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m0_arvalid && m1_arvalid) begin
                  r_grant <= ~r_last_grant;
                  r_state <= ST_ADDR;
               end else if (m0_arvalid) begin
                  r_grant <= 1'b0;
                  r_state <= ST_ADDR;
               end else if (m1_arvalid) begin
                  r_grant <= 1'b1;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // A master withdrawing arvalid keeps its grant; we simply wait.
               if (w_ar_hs) begin
                  r_len_q    <= w_g_arlen;
                  r_beat_cnt <= 8'd0;
                  r_state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_r_hs) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  // Flags both an early rlast and a missing one; the burst
                  // still terminates only on rlast.
                  if (s_rlast != w_len_match) begin
                     r_protocol_err <= 1'b1;
                  end
                  if (s_rlast) begin
                     r_last_grant <= r_grant;
                     r_state      <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant        = r_grant;
   assign busy         = (r_state != ST_IDLE);
   assign protocol_err = r_protocol_err;

   // Silence unused-bit concerns: w_g_arvalid is consumed via s_arvalid.
endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter. Expected
//               read beats are queued per master when driven downstream and
//               compared when they appear on the upstream port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int BW     = ID_W + 2 + 1 + DATA_W;

   logic              clk;
   logic              sys_rst_n;
   logic [ID_W-1:0]   m0_arid,   m1_arid,   s_arid,   m0_rid,   m1_rid,   s_rid;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
   logic [7:0]        m0_arlen,  m1_arlen,  s_arlen;
   logic [2:0]        m0_arsize, m1_arsize, s_arsize;
   logic [1:0]        m0_arburst, m1_arburst, s_arburst;
   logic              m0_arvalid, m1_arvalid, s_arvalid;
   logic              m0_arready, m1_arready, s_arready;
   logic [DATA_W-1:0] m0_rdata,  m1_rdata,  s_rdata;
   logic [1:0]        m0_rresp,  m1_rresp,  s_rresp;
   logic              m0_rlast,  m1_rlast,  s_rlast;
   logic              m0_rvalid, m1_rvalid, s_rvalid;
   logic              m0_rready, m1_rready, s_rready;
   logic              grant, busy, protocol_err;

   int n_pass  = 0;
   int n_total = 0;

   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];

   axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
      .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
      .m0_arready(m0_arready),
      .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
      .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
      .m1_arready(m1_arready),
      .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
      .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .grant(grant), .busy(busy), .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive point: just after the rising edge. Sample point: falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic req(input int m, input logic [ID_W-1:0] id,
                      input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      if (m == 0) begin
         m0_arvalid = 1'b1; m0_arid = id; m0_araddr = addr; m0_arlen = len;
         m0_arsize = 3'd4; m0_arburst = 2'b01;
      end else begin
         m1_arvalid = 1'b1; m1_arid = id; m1_araddr = addr; m1_arlen = len;
         m1_arsize = 3'd4; m1_arburst = 2'b01;
      end
   endtask

   // Entered at a drive point with the FSM in ADDR for master m.
   task automatic addr_phase(input int m, input logic [ID_W-1:0] id,
                             input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      smp();
      chk("addr_grant", grant, m[0]);
      chk("addr_s_arvalid", s_arvalid, 1'b1);
      chk("addr_s_araddr", s_araddr, addr);
      chk("addr_s_arlen_arid", {s_arlen, s_arid}, {len, id});
      s_arready = 1'b1;
      #1;
      chk("addr_arready", {m1_arready, m0_arready}, (m == 0) ? 2'b01 : 2'b10);
      tick();
      s_arready = 1'b0;
      if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
   endtask

   // Entered at a drive point with the FSM in DATA for master m.
   task automatic beat(input int m, input logic [ID_W-1:0] id,
                       input logic [DATA_W-1:0] d, input logic [1:0] resp,
                       input logic last);
      int n = 0;
      if (m == 0) q0.push_back({id, resp, last, d});
      else        q1.push_back({id, resp, last, d});
      s_rvalid = 1'b1; s_rid = id; s_rdata = d; s_rresp = resp; s_rlast = last;
      smp();
      while (!s_rready && n < 20) begin
         tick();
         smp();
         n++;
      end
      if (!s_rready) chk("beat_handshake_timeout", 1'b0, 1'b1);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   // Upstream beat monitor: pop the scoreboard on every upstream handshake.
   always @(negedge clk) begin
      logic [BW-1:0] e;
      if (m0_rvalid && m0_rready) begin
         if (q0.size() == 0) chk("m0_unexpected_beat", 1'b1, 1'b0);
         else begin
            e = q0.pop_front();
            chk("m0_rbeat", {m0_rid, m0_rresp, m0_rlast, m0_rdata}, e);
         end
      end
      if (m1_rvalid && m1_rready) begin
         if (q1.size() == 0) chk("m1_unexpected_beat", 1'b1, 1'b0);
         else begin
            e = q1.pop_front();
            chk("m1_rbeat", {m1_rid, m1_rresp, m1_rlast, m1_rdata}, e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_n = 1'b0;
      m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
      m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      m0_rready = 1'b1;  m1_rready = 1'b1;
      s_arready = 1'b0;
      s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;

      // ---- reset state ----
      tick(); tick();
      smp();
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 1'b0);
      chk("rst_perr", protocol_err, 1'b0);
      chk("rst_s_arvalid", s_arvalid, 1'b0);
      chk("rst_s_rready", s_rready, 1'b0);
      sys_rst_n = 1'b1;
      tick();

      // ---- single request, 4 beats ----
      req(0, 4'h5, 28'h0000100, 8'd3);
      smp();
      chk("idle_no_s_arvalid", s_arvalid, 1'b0);
      chk("idle_no_m0_arready", m0_arready, 1'b0);
      tick();
      addr_phase(0, 4'h5, 28'h0000100, 8'd3);
      for (int k = 0; k < 4; k++)
         beat(0, 4'h5, {96'h0, 32'hC0DE_0000 | k}, 2'b00, (k == 3));
      smp();
      chk("single_busy_clear", busy, 1'b0);
      chk("single_perr", protocol_err, 1'b0);
      tick();

      // ---- tie after reset: m0, then m1, then repeat tie m0 first ----
      do_reset();
      req(0, 4'h1, 28'h0000200, 8'd0);
      req(1, 4'h2, 28'h0000300, 8'd0);
      tick();
      addr_phase(0, 4'h1, 28'h0000200, 8'd0);
      smp();
      chk("tie_m1_waits_data", m1_arready, 1'b0);
      tick();
      beat(0, 4'h1, 128'h1111, 2'b10, 1'b1);
      smp();
      chk("b2b_idle_s_arvalid", s_arvalid, 1'b0);
      chk("b2b_idle_m1_arready", m1_arready, 1'b0);
      chk("b2b_idle_busy", busy, 1'b0);
      tick();
      addr_phase(1, 4'h2, 28'h0000300, 8'd0);
      beat(1, 4'h2, 128'h2222, 2'b00, 1'b1);
      req(0, 4'h3, 28'h0000240, 8'd0);
      req(1, 4'h4, 28'h0000340, 8'd0);
      tick();
      addr_phase(0, 4'h3, 28'h0000240, 8'd0);
      beat(0, 4'h3, 128'h3333, 2'b00, 1'b1);
      tick();
      addr_phase(1, 4'h4, 28'h0000340, 8'd0);
      beat(1, 4'h4, 128'h4444, 2'b01, 1'b1);

      // ---- backpressure on address and data ----
      req(1, 4'h6, 28'h0000400, 8'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("bp_addr_hold", {busy, grant, s_arvalid, m1_arready}, 4'b1110);
         tick();
      end
      addr_phase(1, 4'h6, 28'h0000400, 8'd0);
      m1_rready = 1'b0;
      q1.push_back({4'h6, 2'b00, 1'b1, 128'hBEEF});
      s_rvalid = 1'b1; s_rid = 4'h6; s_rdata = 128'hBEEF; s_rresp = 2'b00; s_rlast = 1'b1;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("bp_s_rready_low", {s_rready, m1_rvalid, busy}, 3'b011);
         tick();
      end
      m1_rready = 1'b1;
      smp();
      chk("bp_s_rready_high", s_rready, 1'b1);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      smp();
      chk("bp_done_busy", busy, 1'b0);
      tick();

      // ---- early rlast (arlen=3, rlast on beat 2) ----
      req(0, 4'h7, 28'h0000500, 8'd3);
      tick();
      addr_phase(0, 4'h7, 28'h0000500, 8'd3);
      beat(0, 4'h7, 128'h50, 2'b00, 1'b0);
      beat(0, 4'h7, 128'h51, 2'b00, 1'b1);
      smp();
      chk("early_rlast_perr", protocol_err, 1'b1);
      chk("early_rlast_idle", busy, 1'b0);
      tick();
      do_reset();
      smp();
      chk("perr_cleared_by_reset", protocol_err, 1'b0);
      tick();

      // ---- missing rlast (arlen=1, rlast on beat 3) ----
      req(0, 4'h8, 28'h0000600, 8'd1);
      tick();
      addr_phase(0, 4'h8, 28'h0000600, 8'd1);
      beat(0, 4'h8, 128'h60, 2'b00, 1'b0);
      beat(0, 4'h8, 128'h61, 2'b00, 1'b0);
      smp();
      chk("late_rlast_perr_still_busy", {protocol_err, busy}, 2'b11);
      tick();
      beat(0, 4'h8, 128'h62, 2'b00, 1'b1);
      smp();
      chk("late_rlast_exit", {protocol_err, busy}, 2'b10);
      tick();

      // ---- reset mid-burst on beat 1 of 4 ----
      req(1, 4'h9, 28'h0000700, 8'd3);
      tick();
      addr_phase(1, 4'h9, 28'h0000700, 8'd3);
      beat(1, 4'h9, 128'h70, 2'b00, 1'b0);
      q1.push_back({4'h9, 2'b00, 1'b0, 128'h71});
      s_rvalid = 1'b1; s_rid = 4'h9; s_rdata = 128'h71; s_rresp = 2'b00; s_rlast = 1'b0;
      sys_rst_n = 1'b0;
      tick();
      smp();
      chk("midrst_state", {busy, grant}, 2'b00);
      chk("midrst_rvalid", {m1_rvalid, m0_rvalid, s_rready}, 3'b000);
      chk("midrst_perr", protocol_err, 1'b0);
      sys_rst_n = 1'b1;
      s_rvalid = 1'b0;
      tick();

      // ---- arrival during a burst ----
      req(0, 4'hA, 28'h0000800, 8'd1);
      tick();
      addr_phase(0, 4'hA, 28'h0000800, 8'd1);
      req(1, 4'hB, 28'h0000900, 8'd0);
      smp();
      chk("arrive_m1_arready_data", {m1_arready, s_arvalid}, 2'b00);
      tick();
      beat(0, 4'hA, 128'hA0, 2'b00, 1'b0);
      beat(0, 4'hA, 128'hA1, 2'b00, 1'b1);
      smp();
      chk("arrive_idle", {busy, m1_arready, s_arvalid}, 3'b000);
      tick();
      addr_phase(1, 4'hB, 28'h0000900, 8'd0);
      beat(1, 4'hB, 128'hB0, 2'b11, 1'b1);
      smp();
      chk("final_busy", busy, 1'b0);
      chk("scoreboard_drained", {q0.size() == 0, q1.size() == 0}, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
